// File: rtl/pio_pkg.sv
// Shared definitions for the PIO interrupt port: register offsets,
// the decoded-register enum and small helpers used by the address decode.
package pio_pkg;

  localparam int PIO_MAX_WIDTH = 32;

  // Byte offsets inside the port's 64-byte window.
  localparam logic [5:0] PIO_OUT     = 6'h00;
  localparam logic [5:0] PIO_CLR     = 6'h04;
  localparam logic [5:0] PIO_SET     = 6'h08;
  localparam logic [5:0] PIO_TGL     = 6'h0C;
  localparam logic [5:0] PIO_DDR     = 6'h10;
  localparam logic [5:0] PIO_PIN     = 6'h14;
  localparam logic [5:0] PIO_RISE_EN = 6'h18;
  localparam logic [5:0] PIO_FALL_EN = 6'h1C;
  localparam logic [5:0] PIO_FLAG    = 6'h20;

  typedef enum logic [3:0] {
    REG_OUT,
    REG_CLR,
    REG_SET,
    REG_TGL,
    REG_DDR,
    REG_PIN,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_FLAG,
    REG_NONE
  } pio_reg_e;

  // Word index (address bits [5:2]) to register; reserved slots map to REG_NONE.
  function automatic pio_reg_e pio_decode(input logic [3:0] word_idx);
    logic [5:0] off;
    pio_reg_e   sel;
    off = {word_idx, 2'b00};
    case (off)
      PIO_OUT:     sel = REG_OUT;
      PIO_CLR:     sel = REG_CLR;
      PIO_SET:     sel = REG_SET;
      PIO_TGL:     sel = REG_TGL;
      PIO_DDR:     sel = REG_DDR;
      PIO_PIN:     sel = REG_PIN;
      PIO_RISE_EN: sel = REG_RISE_EN;
      PIO_FALL_EN: sel = REG_FALL_EN;
      PIO_FLAG:    sel = REG_FLAG;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

  // Ones in the low `w` bits, saturating at the full 32-bit word.
  function automatic logic [31:0] pio_width_mask(input int w);
    logic [31:0] m;
    if (w >= PIO_MAX_WIDTH) m = '1;
    else                    m = (32'h1 << w) - 32'h1;
    return m;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain plus edge detection for the PIO port.
// Edge outputs (and the `prev` register) exist only when PIO_IRQ_EN is defined.
module pio_sync_edge #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync
`ifdef PIO_IRQ_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Metastability chain: pins enter stage 0, the last stage is the clean value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign sync = stage[DEPTH-1];

`ifdef PIO_IRQ_EN
  logic [WIDTH-1:0] prev;

  // One-cycle delayed copy of the synchronised pins for edge comparison.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= '0;
    else      prev <= sync;
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
`endif

endmodule

// File: rtl/pio_irq_port.sv
// Memory-mapped GPIO port with set/clear/toggle, direction, synchronised
// inputs and per-pin edge interrupts. Read data is registered and is zero
// whenever no read was selected, so it can be ORed onto the data bus.
// Build option: PIO_IRQ_EN enables RISE_EN/FALL_EN/FLAG and the irq output.
module pio_irq_port
  import pio_pkg::*;
#(
  parameter int          BUS_ADDR_DATA_LEN = 13,
  parameter int          PORT_WIDTH        = 32,
  parameter logic [31:0] PINMASK           = 32'hFFFF_FFFF,
  parameter logic [31:0] INVERSE_MASK      = 32'h0000_0000,
  parameter logic [31:0] OUT_ENABLED_MASK  = 32'hFFFF_FFFF,
  parameter int          SYNC_STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [31:0]                  bus_dat_in,
  output logic [31:0]                  bus_dat_out,
  input  logic [PORT_WIDTH-1:0]        io_in,
  output logic [PORT_WIDTH-1:0]        io_out,
  output logic [PORT_WIDTH-1:0]        io_oe,
  output logic                         irq
);

  // Bits that exist both physically (width) and by configuration (PINMASK).
  localparam logic [31:0] IMPL_MASK = PINMASK & pio_width_mask(PORT_WIDTH);

  pio_reg_e              reg_sel;
  logic [31:0]           wdata;
  logic [31:0]           out_q;
  logic [31:0]           ddr_q;
  logic [31:0]           pin_w;
  logic [31:0]           rdata;
  logic [PORT_WIDTH-1:0] sync_w;
  logic                  unused_addr;

  assign reg_sel     = pio_decode(addr_dat[5:2]);
  assign wdata       = bus_dat_in & IMPL_MASK;
  assign unused_addr = ^{addr_dat[BUS_ADDR_DATA_LEN-1:6], addr_dat[1:0]};

`ifdef PIO_IRQ_EN
  logic [PORT_WIDTH-1:0] rise_w;
  logic [PORT_WIDTH-1:0] fall_w;

  pio_sync_edge #(
    .WIDTH (PORT_WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (io_in),
    .sync (sync_w),
    .rise (rise_w),
    .fall (fall_w)
  );
`else
  pio_sync_edge #(
    .WIDTH (PORT_WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (io_in),
    .sync (sync_w)
  );
`endif

  assign pin_w = 32'(sync_w) & IMPL_MASK;

  // Output value and direction registers; CLR/SET/TGL modify OUT in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      ddr_q <= '0;
    end else if (wr_dat) begin
      case (reg_sel)
        REG_OUT: out_q <= wdata;
        REG_CLR: out_q <= out_q & ~wdata;
        REG_SET: out_q <= out_q | wdata;
        REG_TGL: out_q <= out_q ^ wdata;
        REG_DDR: ddr_q <= wdata;
        default: ;
      endcase
    end
  end

  // Inversion is applied only at the pin, so OUT reads back what was written.
  assign io_out = PORT_WIDTH'((out_q ^ INVERSE_MASK) & IMPL_MASK);
  assign io_oe  = PORT_WIDTH'(ddr_q & OUT_ENABLED_MASK & IMPL_MASK);

`ifdef PIO_IRQ_EN
  logic [31:0] rise_en_q;
  logic [31:0] fall_en_q;
  logic [31:0] flag_q;
  logic [31:0] flag_d;
  logic [31:0] edge_hit;

  // Flag update: a W1C clear is applied first and new edges ORed on top,
  // so an edge arriving in the clearing cycle is never lost.
  always_comb begin
    edge_hit = ((32'(rise_w) & rise_en_q) | (32'(fall_w) & fall_en_q)) & IMPL_MASK;
    flag_d   = flag_q;
    if (wr_dat && (reg_sel == REG_FLAG)) flag_d = flag_q & ~wdata;
    flag_d   = flag_d | edge_hit;
  end

  // Edge enables, flag register and the registered level interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      flag_q    <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_dat && (reg_sel == REG_RISE_EN)) rise_en_q <= wdata;
      if (wr_dat && (reg_sel == REG_FALL_EN)) fall_en_q <= wdata;
      flag_q <= flag_d;
      irq    <= |(flag_q & (rise_en_q | fall_en_q));
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux; write-only and reserved offsets read as zero.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_OUT:     rdata = out_q;
      REG_DDR:     rdata = ddr_q;
      REG_PIN:     rdata = pin_w;
`ifdef PIO_IRQ_EN
      REG_RISE_EN: rdata = rise_en_q;
      REG_FALL_EN: rdata = fall_en_q;
      REG_FLAG:    rdata = flag_q;
`endif
      default:     rdata = '0;
    endcase
  end

  // Registered read data, zero whenever this port is not being read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        bus_dat_out <= '0;
    else if (rd_dat) bus_dat_out <= rdata;
    else             bus_dat_out <= '0;
  end

endmodule
